// File: rtl/spawn_ficha.sv
// Post-move tile spawner for a 4x4 2048 board: counts empty cells, picks one
// with an LFSR draw, writes a 2 (or rarely a 4) and returns the board.
module spawn_ficha #(
  parameter int          TILE_W    = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mov,
  input  logic [16*TILE_W-1:0] board_in,
  output logic [16*TILE_W-1:0] board_out,
  output logic                 busy,
  output logic                 done,
  output logic                 spawned,
  output logic                 full
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_COUNT  = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [3:0]            rnd_hi_q;
  logic [7:0]            rnd_lo_q;
  logic [16*TILE_W-1:0]  board_q, board_out_q, spawn_board;
  logic [3:0]            idx_q, sel_idx_q;
  logic [4:0]            empty_cnt_q, seen_q, target_q, cnt_final;
  logic [7:0]            divisor, mod_res;
  logic                  spawned_q, full_q;
  logic [15:0]           cell_empty;
  logic [TILE_W-1:0]     new_tile;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_empty
      assign cell_empty[gi] = (board_q[gi*TILE_W +: TILE_W] == '0);
    end
  endgenerate

  // Free-running so the draw depends on when the request arrives.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign cnt_final = empty_cnt_q + {4'b0, cell_empty[idx_q]};
  assign divisor   = {3'b0, (cnt_final == 5'd0) ? 5'd1 : cnt_final};
  assign mod_res   = rnd_lo_q % divisor;
  assign new_tile  = (rnd_hi_q == 4'h0) ? TILE_W'(4) : TILE_W'(2);

  always_comb begin
    spawn_board = board_q;
    for (int i = 0; i < 16; i++) begin
      if (sel_idx_q == 4'(i)) spawn_board[i*TILE_W +: TILE_W] = new_tile;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = mov ? S_COUNT : S_DONE;
      S_COUNT:  if (idx_q == 4'd15) state_d = (cnt_final == 5'd0) ? S_DONE : S_SELECT;
      S_SELECT: if (idx_q == 4'd15) state_d = S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      rnd_hi_q    <= '0;
      rnd_lo_q    <= '0;
      board_q     <= '0;
      board_out_q <= '0;
      idx_q       <= '0;
      sel_idx_q   <= '0;
      empty_cnt_q <= '0;
      seen_q      <= '0;
      target_q    <= '0;
      spawned_q   <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            board_q     <= board_in;
            rnd_hi_q    <= lfsr_q[15:12];
            rnd_lo_q    <= lfsr_q[7:0];
            idx_q       <= '0;
            empty_cnt_q <= '0;
            seen_q      <= '0;
            sel_idx_q   <= '0;
            if (!mov) begin
              board_out_q <= board_in;
              spawned_q   <= 1'b0;
              full_q      <= 1'b0;
            end
          end
        end
        S_COUNT: begin
          idx_q       <= idx_q + 4'd1;
          empty_cnt_q <= cnt_final;
          if (idx_q == 4'd15) begin
            if (cnt_final == 5'd0) begin
              board_out_q <= board_q;
              spawned_q   <= 1'b0;
              full_q      <= 1'b1;
            end else begin
              target_q <= mod_res[4:0];
            end
          end
        end
        // Full 16-cycle rescan even after the hit keeps latency fixed.
        S_SELECT: begin
          idx_q <= idx_q + 4'd1;
          if (cell_empty[idx_q]) begin
            if (seen_q == target_q) sel_idx_q <= idx_q;
            seen_q <= seen_q + 5'd1;
          end
        end
        S_WRITE: begin
          board_q     <= spawn_board;
          board_out_q <= spawn_board;
          spawned_q   <= 1'b1;
          full_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == S_COUNT) || (state_q == S_SELECT) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign board_out = board_out_q;
  assign spawned   = spawned_q;
  assign full      = full_q;

endmodule

// File: tb/tb_spawn_ficha.sv
// Randomized bench for spawn_ficha: a request-level model predicts each
// result and its latency; directed cases pin the model with literal values.
module tb_spawn_ficha;
  localparam int TW = 12;
  localparam int BW = 16 * TW;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, mov = 1'b0;
  logic [BW-1:0] board_in = '0;
  logic [BW-1:0] board_out;
  logic          busy, done, spawned, full;

  spawn_ficha #(.TILE_W(TW), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .mov(mov), .board_in(board_in),
    .board_out(board_out), .busy(busy), .done(done), .spawned(spawned), .full(full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [BW-1:0] mk(input int v[16]);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[i*TW +: TW] = TW'(v[i]);
    return b;
  endfunction

  // ---------------- request-level model ----------------
  logic [15:0]   m_lfsr;
  bit            m_active = 0;
  int            m_age = 0, m_lat = 0;
  logic [BW-1:0] m_res, exp_out = '0;
  logic          m_sp, m_fl, exp_sp = 0, exp_fl = 0;

  task automatic predict(input logic [BW-1:0] b, input logic mv, input logic [15:0] r);
    int empt[$];
    int t;
    empt = {};
    for (int i = 0; i < 16; i++) if (b[i*TW +: TW] == '0) empt.push_back(i);
    m_res = b;
    m_sp  = 0;
    m_fl  = 0;
    if (!mv) m_lat = 1;
    else if (empt.size() == 0) begin m_lat = 17; m_fl = 1; end
    else begin
      t = int'(r[7:0]) % empt.size();
      m_res[empt[t]*TW +: TW] = (r[15:12] == 4'h0) ? TW'(4) : TW'(2);
      m_lat = 34;
      m_sp  = 1;
    end
  endtask

  task automatic publish();
    exp_out = m_res;
    exp_sp  = m_sp;
    exp_fl  = m_fl;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_lfsr = 16'hACE1; m_active = 0; m_age = 0;
      exp_out = '0; exp_sp = 0; exp_fl = 0;
    end else begin
      if (m_active) begin
        if (m_age == m_lat) m_active = 0;
        else begin
          m_age++;
          if (m_age == m_lat) publish();
        end
      end else if (start) begin
        predict(board_in, mov, m_lfsr);
        m_active = 1;
        m_age    = 1;
        if (m_lat == 1) publish();
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk1("done", done, m_active && (m_age == m_lat));
      chk1("busy", busy, m_active && (m_age < m_lat));
      chk("board_out", board_out, exp_out);
      chk1("spawned", spawned, exp_sp);
      chk1("full", full, exp_fl);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issues one request; poke>0 re-asserts start in that busy cycle.
  task automatic req(input logic [BW-1:0] b, input logic mv, input int poke, output int lat);
    start = 1'b1; mov = mv; board_in = b;
    tick();
    start = 1'b0;
    board_in = {6{$urandom()}};
    mov = 1'($urandom_range(0, 1));
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin lat = k; break; end
      start = (poke > 0 && k == poke);
      tick();
    end
    start = 1'b0;
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got none want done within 60 cycles");
    end
  endtask

  initial begin
    int v[16];
    int lat, gap, fours;
    int hits[16];
    logic [BW-1:0] b, mask_out, mask_in;
    bit saw_done;

    #1;
    chk("rst_board_out", board_out, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_spawned", spawned, 1'b0);
    chk1("rst_full", full, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // mov=0 passthrough, start poked on the done cycle
    v = '{0,2,2,0, 0,4,2,2, 2,2,4,0, 4,2,2,4};
    b = mk(v);
    req(b, 1'b0, 0, lat);
    chk_int("mov0_latency", lat, 1);
    chk("mov0_board", board_out, b);
    chk1("mov0_spawned", spawned, 1'b0);
    chk1("mov0_full", full, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk1("done_cycle_start_ignored", busy, 1'b0);
    tick();

    // reset in the middle of a request
    start = 1'b1; mov = 1'b1; board_in = b;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk("midrst_board_out", board_out, '0);
    tick();
    rst = 1'b0;
    saw_done = 0;
    for (int k = 0; k < 30; k++) begin
      if (done) saw_done = 1;
      tick();
    end
    chk1("midrst_no_done", saw_done, 1'b0);
    req(b, 1'b1, 0, lat);
    chk_int("after_rst_latency", lat, 34);
    tick();

    // single empty cell at (2,3); start poked while busy
    for (int i = 0; i < 16; i++) v[i] = 2;
    v[11] = 0;
    b = mk(v);
    req(b, 1'b1, 5, lat);
    chk_int("single_latency", lat, 34);
    chk1("single_cell_2or4", (board_out[11*TW +: TW] == 12'd2) || (board_out[11*TW +: TW] == 12'd4), 1'b1);
    mask_out = board_out; mask_out[11*TW +: TW] = '0;
    mask_in  = b;
    chk("single_others", mask_out, mask_in);
    chk1("single_spawned", spawned, 1'b1);
    tick();

    // full board
    for (int i = 0; i < 16; i++) v[i] = 4;
    b = mk(v);
    req(b, 1'b1, 9, lat);
    chk_int("full_latency", lat, 17);
    chk1("full_flag", full, 1'b1);
    chk1("full_spawned", spawned, 1'b0);
    chk("full_board", board_out, b);
    tick();

    // move-right result, repeated with varied spacing
    v = '{0,0,0,4, 0,0,4,4, 0,0,4,4, 0,4,4,4};
    b = mk(v);
    fours = 0;
    for (int i = 0; i < 16; i++) hits[i] = 0;
    for (int n = 0; n < 256; n++) begin
      req(b, 1'b1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0, lat);
      if (n < 4) chk_int("mr_latency", lat, 34);
      for (int i = 0; i < 16; i++) begin
        if (v[i] == 0 && board_out[i*TW +: TW] != '0) begin
          hits[i]++;
          if (board_out[i*TW +: TW] == 12'd4) fours++;
        end
      end
      if ($urandom_range(0, 5) == 0) start = 1'b1;
      tick();
      start = 1'b0;
      gap = $urandom_range(0, 4);
      repeat (gap) tick();
    end
    for (int i = 0; i < 16; i++) if (v[i] == 0) chk1("mr_cell_hit", hits[i] > 0, 1'b1);
    chk1("mr_fours_in_range", (fours >= 4) && (fours <= 40), 1'b1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
